accum_ctrl: RTL and testbench
=============================

// Module: accum_ctrl
// PURPOSE
//  Hardware sequencer for the switch/LED accumulator on the MAX10 lab board.
//  - Debounces the accumulate and clear push-buttons.
//  - Arbitrates button actions against CPU (Nios II PIO-side) load requests.
//  - Owns the accumulator register that drives LEDR; sits beside the SoC in the top level.
// PARAMETERS
//  WIDTH            8       accumulator / switch / LED width
//  DEBOUNCE_CYCLES  500000  consecutive stable cycles to accept a key level (10 ms @ 50 MHz)
// PORTS
//  Clk        in   1      system clock (MAX10_CLK1_50 domain)
//  Reset      in   1      synchronous, active-high reset
//  key_acc_n  in   1      raw accumulate button, active-low, asynchronous
//  key_clr_n  in   1      raw clear button, active-low, asynchronous
//  sw         in   WIDTH  addend from slide switches, sampled in S_ADD
//  cpu_wr     in   1      CPU load request; held high until cpu_ack
//  cpu_wdata  in   WIDTH  CPU load value; stable while cpu_wr is high
//  cpu_ack    out  1      one-cycle pulse in the cycle cpu_wdata is loaded
//  led        out  WIDTH  accumulator value (drives LEDR)
//  overflow   out  1      sticky carry-out flag
//  busy       out  1      high whenever state != S_IDLE
// BEHAVIOUR
//  Reset
//   - acc=0, overflow=0, cpu_ack=0, state=S_IDLE.
//   - Sync flops=1, debounced levels=1 (released), debounce counters=0.
//   - Reset asserted in any state takes effect at the next edge and aborts the in-flight action.
//   - A key held low through reset yields one press event DEBOUNCE_CYCLES+3 cycles after Reset drops.
//  Key path, per key
//   - 2-flop synchroniser.
//   - Counter increments while the synced level != debounced level; it clears when they match.
//   - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
//   - Press event = one-cycle pulse on a debounced 1->0 transition. Releases generate no event.
//  FSM (states in package)
//   - S_IDLE: priority clr_evt > cpu_wr > acc_evt.
//       clr_evt -> S_CLEAR; cpu_wr -> S_LOAD; acc_evt -> S_ADD.
//   - S_CLEAR (1 cycle): acc<=0, overflow<=0 -> S_WAIT_REL.
//   - S_ADD (1 cycle): {c,acc}<=acc+sw, modulo 2^WIDTH; overflow<=overflow|c -> S_WAIT_REL.
//   - S_LOAD (1 cycle): acc<=cpu_wdata, overflow<=0, cpu_ack=1 -> S_IDLE.
//   - S_WAIT_REL: stay until both debounced keys are released -> S_IDLE.
//       A pending cpu_wr is serviced only after return to S_IDLE.
//  Event and handshake rules
//   - Key events arriving outside S_IDLE are dropped, not queued.
//   - cpu_wr is level-held, so it is never lost. cpu_ack never asserts twice for one request.
//       The CPU must drop cpu_wr the cycle after cpu_ack.
//   - Simultaneous clr_evt and cpu_wr: clear first; load completes after keys are released.
//  Latency
//   - Raw key edge -> led update is exactly DEBOUNCE_CYCLES+4 cycles for a clean press:
//       2 sync + DEBOUNCE_CYCLES + 1 event + 1 action.
//   - cpu_wr seen in S_IDLE -> led and cpu_ack at +1 edge.
//  Outputs
//   - led and overflow are registered with no combinational path from inputs.
//   - busy is decoded from the state register.
// STRUCTURE
//  - accum_ctrl_pkg: state_t enum {S_IDLE,S_CLEAR,S_ADD,S_LOAD,S_WAIT_REL}; action priority constants.
//  - Sub-module key_debounce #(DEBOUNCE_CYCLES)(Clk,Reset,key_n,level,press):
//      synchroniser + counter + edge pulse, instantiated twice.
//      Counter width is $clog2(DEBOUNCE_CYCLES+1).
//  - accum_ctrl holds the FSM and the acc/overflow registers only.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//  1. Reset held 3 cycles -> led=00, overflow=0, cpu_ack=0, busy=0.
//  2. sw=05, key_acc_n low 20 cycles then high ->
//       led=05 exactly 8 cycles after the falling edge.
//     Second press -> led=0A.
//  3. key_acc_n toggled every 2 cycles for 16 cycles, then high -> led unchanged, busy never 1.
//  4. led=F0, sw=20, acc press -> led=10, overflow=1.
//     Then clr press -> led=00, overflow=0.
//  5. cpu_wr=1, cpu_wdata=7F in the same cycle as clr_evt -> led=00,
//       then after key release led=7F with a single cpu_ack pulse.
//  6. Reset asserted while in S_WAIT_REL with key_acc_n still low ->
//       outputs reset next edge.
//     Exactly one new ADD occurs DEBOUNCE_CYCLES+4 cycles after Reset drops.

Source files
------------

// File: rtl/accum_ctrl_pkg.sv
// accum_ctrl_pkg: state encoding and idle-time action arbitration for the accumulator sequencer.
package accum_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ADD,
        S_LOAD,
        S_WAIT_REL
    } state_t;

    // Declaration order is priority order: the earliest pending action wins.
    typedef enum logic [1:0] {
        ACT_CLEAR,
        ACT_LOAD,
        ACT_ADD,
        ACT_NONE
    } action_t;

    function automatic action_t pick_action(input logic clr, input logic load, input logic add);
        return clr ? ACT_CLEAR : load ? ACT_LOAD : add ? ACT_ADD : ACT_NONE;
    endfunction

    function automatic state_t action_state(input action_t a);
        return a == ACT_CLEAR ? S_CLEAR :
               a == ACT_LOAD  ? S_LOAD  :
               a == ACT_ADD   ? S_ADD   : S_IDLE;
    endfunction

endpackage

// File: rtl/accum_ctrl_key_debounce.sv
// key_debounce: two-flop synchroniser, stability counter and press pulse for one active-low key.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic         sync1, sync2;
    logic [CW-1:0] cnt;

    // The press pulse is registered on the same edge the level flips, so the
    // FSM sees it one cycle after the debounced level falls.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
                press <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/accum_ctrl.sv
// accum_ctrl: arbitrates debounced key actions against CPU loads and owns the LED accumulator.
module accum_ctrl
    import accum_ctrl_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             key_acc_n,
    input  logic             key_clr_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             cpu_wr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic             cpu_ack,
    output logic [WIDTH-1:0] led,
    output logic             overflow,
    output logic             busy
);

    state_t         state, idle_next;
    logic           acc_level, acc_evt, clr_level, clr_evt;
    logic [WIDTH:0] sum;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_acc_key (
        .Clk   (Clk),
        .Reset (Reset),
        .key_n (key_acc_n),
        .level (acc_level),
        .press (acc_evt)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_key (
        .Clk   (Clk),
        .Reset (Reset),
        .key_n (key_clr_n),
        .level (clr_level),
        .press (clr_evt)
    );

    // A request whose ack is still showing is already done; this keeps one
    // ack per request while the CPU takes a cycle to drop cpu_wr.
    always_comb begin
        sum       = {1'b0, led} + {1'b0, sw};
        idle_next = action_state(pick_action(clr_evt, cpu_wr && !cpu_ack, acc_evt));
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= S_IDLE;
            led      <= '0;
            overflow <= 1'b0;
            cpu_ack  <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            case (state)
                S_IDLE: state <= idle_next;
                S_CLEAR: begin
                    led      <= '0;
                    overflow <= 1'b0;
                    state    <= S_WAIT_REL;
                end
                S_ADD: begin
                    led      <= sum[WIDTH-1:0];
                    overflow <= overflow | sum[WIDTH];
                    state    <= S_WAIT_REL;
                end
                S_LOAD: begin
                    led      <= cpu_wdata;
                    overflow <= 1'b0;
                    cpu_ack  <= 1'b1;
                    state    <= S_IDLE;
                end
                S_WAIT_REL: state <= (acc_level && clr_level) ? S_IDLE : S_WAIT_REL;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = state != S_IDLE;

endmodule

// File: tb/tb_accum_ctrl.sv
// tb_accum_ctrl: directed scoreboard bench for accum_ctrl with a short debounce window.
module tb_accum_ctrl;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_acc_n = 1'b1;
    logic         key_clr_n = 1'b1;
    logic         cpu_wr = 1'b0;
    logic [W-1:0] sw = '0;
    logic [W-1:0] cpu_wdata = '0;
    logic         cpu_ack, overflow, busy;
    logic [W-1:0] led;

    logic [W:0]   exp_q[$];
    logic [W-1:0] m_led = '0;
    logic         m_ovf = 1'b0;
    int           checks = 0;
    int           errors = 0;

    accum_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .Clk       (clk),
        .Reset     (rst),
        .key_acc_n (key_acc_n),
        .key_clr_n (key_clr_n),
        .sw        (sw),
        .cpu_wr    (cpu_wr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .led       (led),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_model();
        exp_q.push_back({m_led, m_ovf});
    endtask

    task automatic check_sb(input string tag);
        logic [W:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, 32'({led, overflow}), 32'(e));
        end
    endtask

    task automatic press(input bit clr, input string tag);
        logic [W:0] s;
        push_model();
        if (clr) begin
            m_led = '0;
            m_ovf = 1'b0;
        end else begin
            s = {1'b0, m_led} + {1'b0, sw};
            m_led = s[W-1:0];
            m_ovf = m_ovf | s[W];
        end
        push_model();
        if (clr) key_clr_n = 1'b0; else key_acc_n = 1'b0;
        tick(D + 3);
        check_sb({tag, "_pre"});
        tick(1);
        check_sb(tag);
        check({tag, "_busy"}, 32'(busy), 32'(1));
        tick(12);
        key_acc_n = 1'b1;
        key_clr_n = 1'b1;
        tick(D + 6);
        check({tag, "_idle"}, 32'(busy), 32'(0));
    endtask

    task automatic cpu_load(input logic [W-1:0] v, input string tag);
        int acks = 0;
        m_led = v;
        m_ovf = 1'b0;
        push_model();
        cpu_wr = 1'b1;
        cpu_wdata = v;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (cpu_ack) begin
                if (acks == 0) begin
                    check_sb(tag);
                    check({tag, "_lat"}, 32'(i), 32'(1));
                    cpu_wr = 1'b0;
                end
                acks++;
            end
        end
        check({tag, "_acks"}, 32'(acks), 32'(1));
    endtask

    initial begin
        logic busy_seen;
        int   acks;

        // 1. reset state
        tick(3);
        push_model();
        check_sb("reset_led_ovf");
        check("reset_ack", 32'(cpu_ack), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        rst = 1'b0;
        tick(2);

        // 2. two clean accumulate presses
        sw = 8'h05;
        press(1'b0, "acc1");
        press(1'b0, "acc2");

        // 3. bouncing key never reaches the debounce threshold
        busy_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            key_acc_n = i[0];
            for (int j = 0; j < 2; j++) begin
                tick(1);
                busy_seen = busy_seen | busy;
            end
        end
        key_acc_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            busy_seen = busy_seen | busy;
        end
        push_model();
        check_sb("bounce_led");
        check("bounce_busy", 32'(busy_seen), 32'(0));

        // 4. carry out sets sticky overflow, clear resets it
        cpu_load(8'hF0, "load_f0");
        sw = 8'h20;
        press(1'b0, "acc_ovf");
        press(1'b1, "clr");

        // 5. clear and CPU load in the same cycle: clear wins, load follows release
        cpu_load(8'h55, "load_55");
        key_clr_n = 1'b0;
        tick(D + 2);
        cpu_wr = 1'b1;
        cpu_wdata = 8'h7F;
        tick(1);
        push_model();
        check_sb("race_pre");
        check("race_busy", 32'(busy), 32'(1));
        tick(1);
        m_led = '0;
        m_ovf = 1'b0;
        push_model();
        check_sb("race_clr");
        check("race_noack", 32'(cpu_ack), 32'(0));
        tick(10);
        push_model();
        check_sb("race_hold");
        key_clr_n = 1'b1;
        m_led = 8'h7F;
        push_model();
        acks = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (cpu_ack) begin
                if (acks == 0) begin
                    check_sb("race_load");
                    cpu_wr = 1'b0;
                end
                acks++;
            end
        end
        check("race_acks", 32'(acks), 32'(1));

        // 6. reset during S_WAIT_REL with the key still held
        sw = 8'h03;
        key_acc_n = 1'b0;
        tick(D + 4);
        m_led = 8'h82;
        push_model();
        check_sb("pre_rst_add");
        check("pre_rst_busy", 32'(busy), 32'(1));
        rst = 1'b1;
        tick(1);
        m_led = '0;
        m_ovf = 1'b0;
        push_model();
        check_sb("rst_led");
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_ack", 32'(cpu_ack), 32'(0));
        tick(1);
        rst = 1'b0;
        tick(D + 3);
        push_model();
        check_sb("post_rst_pre");
        tick(1);
        m_led = 8'h03;
        push_model();
        check_sb("post_rst_add");
        tick(20);
        push_model();
        check_sb("post_rst_single");
        check("post_rst_busy", 32'(busy), 32'(1));
        key_acc_n = 1'b1;
        tick(D + 6);
        check("post_rst_idle", 32'(busy), 32'(0));

        check("sb_drained", 32'(exp_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
